// File: rtl/clarvi_pio_pkg.sv
// clarvi_pio_pkg: register map and STATUS bit layout shared by the clarvi
// output PIO and its blink timer.
package clarvi_pio_pkg;

    // Word addresses of the PIO register map
    localparam logic [2:0] PIO_ADDR_DATA         = 3'd0;
    localparam logic [2:0] PIO_ADDR_BLINK_MASK   = 3'd1;
    localparam logic [2:0] PIO_ADDR_BLINK_PERIOD = 3'd2;
    localparam logic [2:0] PIO_ADDR_STATUS       = 3'd3;
    localparam logic [2:0] PIO_ADDR_SET          = 3'd4;
    localparam logic [2:0] PIO_ADDR_CLEAR        = 3'd5;
    localparam logic [2:0] PIO_ADDR_TOGGLE       = 3'd6;
    localparam logic [2:0] PIO_ADDR_RESERVED     = 3'd7;

    // Bit position of the blink phase inside STATUS
    localparam int PIO_STATUS_PHASE = 0;

endpackage

// File: rtl/clarvi_pio_blink_timer.sv
// clarvi_pio_blink_timer: free-running half-period counter that inverts
// 'phase' every period+1 clocks. A zero period parks the timer with phase
// low, and 'restart' (a period register write) restarts the half-period
// without inverting phase.
module clarvi_pio_blink_timer
    import clarvi_pio_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    logic [PERIOD_W-1:0] counter;
    logic                phase_q;

    // Count clocks within the current half-period and invert phase at the terminal count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
            phase_q <= 1'b0;
        end else if (period == '0) begin
            counter <= '0;
            phase_q <= 1'b0;
        end else if (restart) begin
            counter <= '0;
        end else if (counter == period) begin
            counter <= '0;
            phase_q <= ~phase_q;
        end else begin
            counter <= counter + PERIOD_W'(1);
        end
    end

    // A zero period forces phase low as soon as the period register holds zero
    assign phase = phase_q & (period != '0);

endmodule

// File: rtl/clarvi_pio_out.sv
// clarvi_pio_out: parametrised zero-wait-state Avalon-MM output PIO with
// atomic set/clear/toggle aliases. Define CLARVI_PIO_BLINK_EN to build the
// per-bit blink generator (BLINK_MASK, BLINK_PERIOD and STATUS registers).
module clarvi_pio_out
    import clarvi_pio_pkg::*;
#(
    parameter int               WIDTH       = 10,
    parameter int               PERIOD_W    = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wd           = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // DATA register and its atomic write-one set/clear/toggle aliases
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                PIO_ADDR_DATA:   data <= wd;
                PIO_ADDR_SET:    data <= data | wd;
                PIO_ADDR_CLEAR:  data <= data & ~wd;
                PIO_ADDR_TOGGLE: data <= data ^ wd;
                default:         data <= data;
            endcase
        end
    end

`ifdef CLARVI_PIO_BLINK_EN
    logic [WIDTH-1:0]    mask;
    logic [PERIOD_W-1:0] period;
    logic                restart;
    logic                phase;

    assign restart = wr_en && (address == PIO_ADDR_BLINK_PERIOD);

    // Blink mask and period registers; changing the mask leaves the timer alone
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask   <= '0;
            period <= '0;
        end else if (wr_en) begin
            if (address == PIO_ADDR_BLINK_MASK) begin
                mask <= wd;
            end
            if (address == PIO_ADDR_BLINK_PERIOD) begin
                period <= writedata[PERIOD_W-1:0];
            end
        end
    end

    clarvi_pio_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period),
        .restart (restart),
        .phase   (phase)
    );

    // Blinking bits are pulled low during the high phase
    assign out_port = data & ~(mask & {WIDTH{phase}});

    // Combinational register read mux, unused upper bits read zero
    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA,
            PIO_ADDR_SET,
            PIO_ADDR_CLEAR,
            PIO_ADDR_TOGGLE:       readdata = 32'(data);
            PIO_ADDR_BLINK_MASK:   readdata = 32'(mask);
            PIO_ADDR_BLINK_PERIOD: readdata = 32'(period);
            PIO_ADDR_STATUS:       readdata[PIO_STATUS_PHASE] = phase;
            default:               readdata = '0;
        endcase
    end
`else
    assign out_port = data;

    // Combinational register read mux, blink registers absent and read zero
    always_comb begin
        readdata = '0;
        case (address)
            PIO_ADDR_DATA,
            PIO_ADDR_SET,
            PIO_ADDR_CLEAR,
            PIO_ADDR_TOGGLE: readdata = 32'(data);
            default:         readdata = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_clarvi_pio_out.sv
// tb_clarvi_pio_out: self-checking bench for clarvi_pio_out with a
// behavioural register/blink model compared every cycle, plus directed
// literal checks. Follows CLARVI_PIO_BLINK_EN like the design.
module tb_clarvi_pio_out;

    localparam int          W  = 10;
    localparam int          PW = 24;
    localparam logic [W-1:0] RV = 10'h155;

    logic          clk;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;

    int checks;
    int passes;

    // Behavioural model state
    logic [W-1:0]  m_data;
    logic [W-1:0]  m_mask;
    logic [PW-1:0] m_period;
    int            m_elapsed;
    logic          m_phase;

    clarvi_pio_out #(
        .WIDTH       (W),
        .PERIOD_W    (PW),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: registers by bus rules; blink as half-periods of period+1 clocks
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data    <= RV;
            m_mask    <= '0;
            m_period  <= '0;
            m_elapsed <= 0;
            m_phase   <= 1'b0;
        end else begin
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data <= writedata[W-1:0];
                    3'd4: m_data <= m_data | writedata[W-1:0];
                    3'd5: m_data <= m_data & ~writedata[W-1:0];
                    3'd6: m_data <= m_data ^ writedata[W-1:0];
                    default: ;
                endcase
            end
`ifdef CLARVI_PIO_BLINK_EN
            if (chipselect && !write_n && address == 3'd1) m_mask <= writedata[W-1:0];
            if (chipselect && !write_n && address == 3'd2) m_period <= writedata[PW-1:0];
            if (m_period == 0) begin
                m_elapsed <= 0;
                m_phase   <= 1'b0;
            end else if (chipselect && !write_n && address == 3'd2) begin
                m_elapsed <= 0;
            end else if (m_elapsed + 1 == int'(m_period) + 1) begin
                m_elapsed <= 0;
                m_phase   <= ~m_phase;
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
`endif
        end
    end

    function automatic logic visPhase();
        return m_phase && (m_period != 0);
    endfunction

    function automatic logic [31:0] expOut();
        logic [W-1:0] blank;
        blank = visPhase() ? m_mask : '0;
        return 32'(m_data & ~blank);
    endfunction

    function automatic logic [31:0] expRd(input logic [2:0] a);
        case (a)
            3'd0, 3'd4, 3'd5, 3'd6: return 32'(m_data);
`ifdef CLARVI_PIO_BLINK_EN
            3'd1: return 32'(m_mask);
            3'd2: return 32'(m_period);
            3'd3: return {31'b0, visPhase()};
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        checkOutput("model out_port", 32'(out_port), expOut());
        checkOutput("model readdata", readdata, expRd(address));
    end

    // Drive one bus cycle now and hold it across the next rising edge
    task automatic applyStimulus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b0, a, d);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b1, address, 32'h0);
    endtask

    task automatic readCheck(input string name, input logic [2:0] a, input logic [31:0] expected);
        address = a;
        #1;
        checkOutput(name, readdata, expected);
    endtask

    // Count rising edges until out_port[0] changes, bounded
    task automatic countToFlip(output int n);
        logic b;
        b = out_port[0];
        n = 0;
        while (out_port[0] == b && n < 40) begin
            idleCycle();
            n++;
        end
    endtask

    initial begin
        int n;
        int guard;
        checks     = 0;
        passes     = 0;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_port", 32'(out_port), 32'h155);
        readCheck("reset DATA", 3'd0, 32'h155);
        readCheck("reset MASK", 3'd1, 32'h0);
        readCheck("reset PERIOD", 3'd2, 32'h0);
        readCheck("reset STATUS", 3'd3, 32'h0);
        readCheck("reset reserved", 3'd7, 32'h0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Atomic aliases
        writeReg(3'd0, 32'h0F0);
        writeReg(3'd4, 32'h003);
        readCheck("SET", 3'd0, 32'h0F3);
        writeReg(3'd5, 32'h030);
        readCheck("CLEAR", 3'd5, 32'h0C3);
        writeReg(3'd6, 32'h3FF);
        readCheck("TOGGLE", 3'd6, 32'h33C);
        checkOutput("TOGGLE out_port", 32'(out_port), 32'h33C);
        writeReg(3'd4, 32'h0);
        readCheck("SET zero", 3'd0, 32'h33C);
        writeReg(3'd0, 32'hFFFF_FC00);
        readCheck("DATA upper ignored", 3'd0, 32'h0);
        writeReg(3'd7, 32'hFFFF_FFFF);
        readCheck("reserved write", 3'd7, 32'h0);
        readCheck("reserved no side effect", 3'd0, 32'h0);

`ifdef CLARVI_PIO_BLINK_EN
        // Blink with period 3: half-period of 4 clocks on bit 0
        writeReg(3'd0, 32'h3FF);
        writeReg(3'd1, 32'h001);
        writeReg(3'd2, 32'h3);
        countToFlip(n);
        checkOutput("blink first half", 32'(n), 32'd4);
        checkOutput("blink low", 32'(out_port), 32'h3FE);
        readCheck("STATUS high", 3'd3, 32'h1);
        countToFlip(n);
        checkOutput("blink second half", 32'(n), 32'd4);
        checkOutput("blink high", 32'(out_port), 32'h3FF);
        readCheck("STATUS low", 3'd3, 32'h0);

        // Period write on the terminal-count edge wins
        guard = 0;
        while (m_elapsed != 3 && guard < 20) begin
            idleCycle();
            guard++;
        end
        checkOutput("terminal wait", 32'(guard < 20), 32'h1);
        writeReg(3'd2, 32'h5);
        checkOutput("no flip at terminal", 32'(out_port), 32'h3FF);
        countToFlip(n);
        checkOutput("new period half", 32'(n), 32'd6);
        checkOutput("after new period", 32'(out_port), 32'h3FE);

        // Mask change keeps phase
        writeReg(3'd1, 32'h003);
        checkOutput("mask change", 32'(out_port), 32'h3FC);

        // Zero period forces phase low
        writeReg(3'd2, 32'h0);
        checkOutput("period zero out", 32'(out_port), 32'h3FF);
        readCheck("period zero STATUS", 3'd3, 32'h0);

        // Reset mid-blink
        writeReg(3'd2, 32'h2);
        guard = 0;
        while (!visPhase() && guard < 20) begin
            idleCycle();
            guard++;
        end
        checkOutput("phase high wait", 32'(out_port), 32'h3FC);
`else
        // Blink registers absent
        writeReg(3'd0, 32'h2A5);
        writeReg(3'd1, 32'h3FF);
        writeReg(3'd2, 32'h5);
        readCheck("no MASK", 3'd1, 32'h0);
        readCheck("no PERIOD", 3'd2, 32'h0);
        readCheck("no STATUS", 3'd3, 32'h0);
        repeat (8) idleCycle();
        checkOutput("out equals DATA", 32'(out_port), 32'h2A5);
`endif
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset out_port", 32'(out_port), 32'h155);
        readCheck("async reset DATA", 3'd0, 32'h155);
        readCheck("async reset MASK", 3'd1, 32'h0);
        readCheck("async reset PERIOD", 3'd2, 32'h0);
        readCheck("async reset STATUS", 3'd3, 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized bus traffic checked against the model each cycle
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = (a == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
            applyStimulus(($urandom % 4) != 0, ($urandom % 2) == 1, a, d);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        repeat (4) idleCycle();

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
